cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Host-side controller that loads a program into the 8-bit CPU's 16x8 RAM and then sequences its execution: run, single-step by instruction, stop, and halt detection.
- Owns the CPU's reset (active-high, as the core expects) and clock-enable, and the RAM load write port.
- Sits between a host byte stream or debug port and the CPU core.
- Also counts executed CPU cycles for debug and LED display.

Parameters:
ADDR_W, 4, RAM address width; the load writes 2**ADDR_W bytes.
DATA_W, 8, RAM word and stream byte width.
RST_CYCLES, 2, number of cycles cpu_reset is held high before the CPU is released.
CNT_W, 16, width of the cycle counter.

Ports:
clk  in  1  system clock, single domain
reset_n  in  1  asynchronous active-low reset
cmd_load  in  1  one-cycle pulse: begin program load
cmd_run  in  1  one-cycle pulse: free-run the CPU
cmd_step  in  1  one-cycle pulse: execute exactly one instruction
cmd_stop  in  1  one-cycle pulse: pause the CPU, or abort a load
in_valid  in  1  load byte valid
in_data  in  DATA_W  load byte
in_ready  out  1  load byte accepted when in_valid && in_ready
cpu_halted  in  1  CPU halt control signal (HLT decoded)
cpu_stage  in  3  CPU instruction step counter (0..5, 6 = halted)
mem_we  out  1  RAM load write strobe
mem_addr  out  ADDR_W  RAM load address
mem_wdata  out  DATA_W  RAM load data
cpu_reset  out  1  active-high reset to the CPU core
cpu_clk_en  out  1  CPU clock enable
load_done  out  1  one-cycle pulse when the final byte is written
busy  out  1  high in LOAD, RESET, STEP
state  out  3  current state encoding, for LEDs
cycle_cnt  out  CNT_W  count of cycles with cpu_clk_en=1, saturating

Behaviour:
- Reset values (async, reset_n low): state=IDLE, cpu_reset=1, cpu_clk_en=0, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, cycle_cnt=0. Reset mid-load or mid-run returns to IDLE immediately; RAM contents are untouched.
- States: IDLE=0, LOAD=1, RESET=2, PAUSED=3, RUN=4, STEP=5, HALTED=6.
- Command priority when several pulses share a cycle: load > stop > step > run.
- IDLE: cpu_reset=1, cpu_clk_en=0.
  - cmd_load -> LOAD.
  - cmd_run or cmd_step -> RESET, then RUN or STEP respectively (the pending command is latched).
- LOAD: cpu_reset=1, in_ready=1.
  - Each accepted byte drives mem_we=1 with mem_addr=ptr and mem_wdata=in_data, registered, so the write occurs one cycle after acceptance. ptr then increments.
  - Accepting byte 2**ADDR_W-1 pulses load_done with the last write and goes to RESET. Pending command is PAUSED; cycle_cnt clears.
  - cmd_stop aborts to IDLE: no load_done, bytes already written remain.
  - cmd_load while in LOAD restarts ptr at 0.
- RESET: cpu_reset=1 for exactly RST_CYCLES cycles, then drop to 0 and enter the latched target state.
- PAUSED: cpu_reset=0, cpu_clk_en=0. cmd_run -> RUN; cmd_step -> STEP; cmd_load -> LOAD.
- RUN: cpu_clk_en=1.
  - cmd_stop -> PAUSED, with cpu_clk_en=0 on the next cycle.
  - cpu_halted=1 or cpu_stage==6 -> HALTED.
- STEP: cpu_clk_en=1 until an instruction boundary, i.e. cpu_stage has been seen !=0 and then returns to 0. cpu_clk_en drops in that same cycle (combinational on cpu_stage==0 && seen_nonzero) and the state goes to PAUSED.
  - A jump that resets the stage counter counts as a boundary.
  - Halt detected during STEP -> HALTED.
  - cmd_stop -> PAUSED.
- HALTED: cpu_clk_en=0. cmd_run or cmd_step restarts via RESET. cmd_load -> LOAD.
- cycle_cnt: increments on every cycle with cpu_clk_en=1 and saturates at all-ones. It clears on entry to RESET.
- in_valid outside LOAD is ignored (in_ready=0, no write).
- cpu_clk_en and cpu_reset are never both 1.

Decomposition:
- Package cpu_ctrl_pkg: state enum (3-bit encodings above), stage constants STAGE_FETCH=0, STAGE_HALT=6, and the default widths.
- One natural sub-module, cpu_load_seq: the LOAD pointer, registered write port and load_done generation, with a start/abort/done interface to the main FSM.

Test Plan:
- Load 16 bytes 0x51,0x4E,...,0x00 with in_valid held high -> mem_we on 16 consecutive cycles, addresses 0..15 with matching data; load_done on the 16th write; state goes 1->2->3; cpu_reset high for 2 cycles after the last write.
- Load with in_valid toggling every other cycle -> 16 writes, no skipped or duplicate addresses, load_done exactly once.
- After load, cmd_step with the model CPU stage sequence 0,1,2,3,4,5,0 -> cpu_clk_en high for 6 cycles then low at stage 0; state=PAUSED; cycle_cnt=6.
- cmd_run, then cpu_halted asserted after 40 cycles -> state=HALTED, cpu_clk_en=0 from the next cycle, cycle_cnt=40. A subsequent cmd_run gives a 2-cycle cpu_reset, then RUN, with cycle_cnt cleared.
- cmd_stop after byte 7 of a load -> state=IDLE, no load_done, in_ready=0. Same-cycle cmd_load+cmd_run in PAUSED -> LOAD wins.
- Assert reset_n low mid-RUN -> all outputs at reset values asynchronously (cpu_reset=1, cpu_clk_en=0, state=0).

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared types and constants for the CPU run controller.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RESET  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] STAGE_FETCH = 3'd0;
    localparam logic [2:0] STAGE_HALT  = 3'd6;

    // The core is held in reset whenever no program may be executing.
    function automatic logic holds_cpu_reset(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_RESET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_load_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_load_seq
// Purpose  : Streams host bytes into the CPU RAM through a registered port.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_load_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              last_accept,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              load_done
);

    logic [ADDR_W-1:0] r_ptr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_done;
    logic              w_accept;
    logic [ADDR_W-1:0] w_ptr;

    // A restart lands a same-cycle byte at address 0.
    assign w_ptr       = start ? '0 : r_ptr;
    assign in_ready    = active && !abort;
    assign w_accept    = in_ready && in_valid;
    assign last_accept = w_accept && (w_ptr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= w_accept;
            r_done <= last_accept;
            if (w_accept) begin
                r_addr  <= w_ptr;
                r_wdata <= in_data;
            end
            if (!active)
                r_ptr <= '0;
            else if (w_accept)
                r_ptr <= w_ptr + ADDR_W'(1);
            else if (start)
                r_ptr <= '0;
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign load_done = r_done;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Loads the CPU program RAM and sequences run / step / stop / halt.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_halted,
    input  logic [2:0]        cpu_stage,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              cpu_clk_en,
    output logic              load_done,
    output logic              busy,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            r_state;
    state_t            r_target;
    state_t            w_next_state;
    state_t            w_next_target;
    logic [RC_W-1:0]   r_rst_cnt;
    logic              r_seen;
    logic              r_cpu_reset;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic              w_load, w_stop, w_step, w_run;
    logic              w_halt, w_boundary, w_last, w_rst_end, w_enter_reset;

    // Fixed command priority: load > stop > step > run.
    assign w_load = cmd_load;
    assign w_stop = !cmd_load && cmd_stop;
    assign w_step = !cmd_load && !cmd_stop && cmd_step;
    assign w_run  = !cmd_load && !cmd_stop && !cmd_step && cmd_run;

    assign w_halt     = cpu_halted || (cpu_stage == STAGE_HALT);
    assign w_boundary = (r_state == ST_STEP) && (cpu_stage == STAGE_FETCH) && r_seen;
    assign w_rst_end  = (r_rst_cnt == RC_W'(RST_CYCLES - 1));

    cpu_load_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_load_seq (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (r_state == ST_LOAD),
        .start       (w_load),
        .abort       (w_stop),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .last_accept (w_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .load_done   (load_done)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_target = r_target;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (w_load) begin
                    w_next_state = ST_LOAD;
                end else if (w_step) begin
                    w_next_state  = ST_RESET;
                    w_next_target = ST_STEP;
                end else if (w_run) begin
                    w_next_state  = ST_RESET;
                    w_next_target = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (w_stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_last && !w_load) begin
                    w_next_state  = ST_RESET;
                    w_next_target = ST_PAUSED;
                end
            end
            ST_RESET:  if (w_rst_end) w_next_state = r_target;
            ST_PAUSED: begin
                if (w_load)      w_next_state = ST_LOAD;
                else if (w_step) w_next_state = ST_STEP;
                else if (w_run)  w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_halt)      w_next_state = ST_HALTED;
                else if (w_stop) w_next_state = ST_PAUSED;
            end
            ST_STEP: begin
                if (w_halt)                      w_next_state = ST_HALTED;
                else if (w_stop || w_boundary)   w_next_state = ST_PAUSED;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_enter_reset = (w_next_state == ST_RESET) && (r_state != ST_RESET);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_target    <= ST_PAUSED;
            r_rst_cnt   <= '0;
            r_seen      <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_target    <= w_next_target;
            r_cpu_reset <= holds_cpu_reset(w_next_state);
            if (w_enter_reset)
                r_rst_cnt <= '0;
            else if (r_state == ST_RESET)
                r_rst_cnt <= r_rst_cnt + RC_W'(1);
            // Boundary tracking restarts on every entry to STEP.
            if (r_state == ST_STEP && w_next_state == ST_STEP)
                r_seen <= r_seen || (cpu_stage != STAGE_FETCH);
            else
                r_seen <= 1'b0;
            if (w_enter_reset)
                r_cycle_cnt <= '0;
            else if (cpu_clk_en && (r_cycle_cnt != {CNT_W{1'b1}}))
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign cpu_clk_en = (r_state == ST_RUN) || ((r_state == ST_STEP) && !w_boundary);
    assign cpu_reset  = r_cpu_reset;
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_RESET) || (r_state == ST_STEP);
    assign state      = r_state;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed self-checking bench for cpu_run_ctrl with a stage model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_load, cmd_run, cmd_step, cmd_stop;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_halted;
    logic [2:0]  cpu_stage;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_reset, cpu_clk_en, load_done, busy;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] m_stage = 3'd0;
    logic       force_halt_stage = 1'b0;

    logic [7:0] prog [16] = '{8'h51, 8'h4E, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h00};

    cpu_run_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_load   (cmd_load),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_stop   (cmd_stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_halted (cpu_halted),
        .cpu_stage  (cpu_stage),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .load_done  (load_done),
        .busy       (busy),
        .state      (state),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Model CPU: stage walks 0..5 while enabled, cleared by its reset.
    always @(posedge clk) begin
        if (cpu_reset)
            m_stage <= 3'd0;
        else if (cpu_clk_en)
            m_stage <= (m_stage == 3'd5) ? 3'd0 : m_stage + 3'd1;
    end
    assign cpu_stage = force_halt_stage ? 3'd6 : m_stage;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wr;
        int n_done;
        reset_n = 1'b0; cmd_load = 0; cmd_run = 0; cmd_step = 0; cmd_stop = 0;
        in_valid = 0; in_data = 8'h00; cpu_halted = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_cpu_reset", cpu_reset, 1);
        check_eq("rst_clk_en", cpu_clk_en, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_load_done", load_done, 0);
        check_eq("rst_cycle_cnt", cycle_cnt, 0);
        reset_n = 1'b1;
        tick();

        // Bytes offered outside LOAD are ignored.
        in_valid = 1; in_data = 8'hAA; #1;
        check_eq("idle_in_ready", in_ready, 0);
        tick();
        check_eq("idle_no_write", mem_we, 0);
        in_valid = 0;

        // Full load with in_valid held high.
        cmd_load = 1; tick(); cmd_load = 0;
        check_eq("load_state", state, 1);
        check_eq("load_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1; in_data = prog[i];
            tick();
            check_eq("ld_we", mem_we, 1);
            check_eq("ld_addr", mem_addr, i);
            check_eq("ld_data", mem_wdata, prog[i]);
            check_eq("ld_done", load_done, (i == 15) ? 1 : 0);
            check_eq("ld_state", state, (i == 15) ? 2 : 1);
            check_eq("ld_cpu_reset", cpu_reset, 1);
        end
        in_valid = 0;
        tick();
        check_eq("rst1_state", state, 2);
        check_eq("rst1_cpu_reset", cpu_reset, 1);
        check_eq("rst1_done_low", load_done, 0);
        check_eq("rst1_we_low", mem_we, 0);
        tick();
        check_eq("paused_state", state, 3);
        check_eq("paused_cpu_reset", cpu_reset, 0);
        check_eq("paused_clk_en", cpu_clk_en, 0);

        // Single step over stages 0..5 back to 0.
        cmd_step = 1; tick(); cmd_step = 0;
        check_eq("step_state", state, 5);
        for (int i = 0; i < 6; i++) begin
            check_eq("step_clk_en", cpu_clk_en, 1);
            tick();
        end
        check_eq("step_boundary_clk_en", cpu_clk_en, 0);
        check_eq("step_cnt", cycle_cnt, 6);
        tick();
        check_eq("step_done_state", state, 3);
        check_eq("step_done_cnt", cycle_cnt, 6);

        // Load with in_valid toggling every other cycle.
        cmd_load = 1; tick(); cmd_load = 0;
        check_eq("tload_state", state, 1);
        n_wr = 0; n_done = 0;
        for (int k = 0; k < 32; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = prog[k / 2] ^ 8'hFF;
            tick();
            check_eq("tld_we", mem_we, (k % 2 == 0) ? 1 : 0);
            if (mem_we) begin
                check_eq("tld_addr", mem_addr, n_wr);
                check_eq("tld_data", mem_wdata, prog[n_wr] ^ 8'hFF);
                n_wr++;
            end
            if (load_done) n_done++;
        end
        in_valid = 0;
        check_eq("tld_writes", n_wr, 16);
        check_eq("tld_done_once", n_done, 1);
        check_eq("tld_state_reset", state, 2);
        tick();
        check_eq("tld_paused", state, 3);
        check_eq("tld_cnt_clear", cycle_cnt, 0);

        // Free run, halt after 40 enabled cycles.
        cmd_run = 1; tick(); cmd_run = 0;
        check_eq("run_state", state, 4);
        check_eq("run_clk_en", cpu_clk_en, 1);
        repeat (39) tick();
        cpu_halted = 1; tick(); cpu_halted = 0;
        check_eq("halt_state", state, 6);
        check_eq("halt_clk_en", cpu_clk_en, 0);
        check_eq("halt_cnt", cycle_cnt, 40);
        check_eq("halt_busy", busy, 0);

        // Restart from HALTED goes through a 2-cycle reset.
        cmd_run = 1; tick(); cmd_run = 0;
        check_eq("rerun_state_r1", state, 2);
        check_eq("rerun_cpu_reset_r1", cpu_reset, 1);
        check_eq("rerun_cnt_clear", cycle_cnt, 0);
        tick();
        check_eq("rerun_state_r2", state, 2);
        check_eq("rerun_cpu_reset_r2", cpu_reset, 1);
        tick();
        check_eq("rerun_state_run", state, 4);
        check_eq("rerun_cpu_reset_low", cpu_reset, 0);

        // Halt detected through stage 6.
        repeat (3) tick();
        force_halt_stage = 1; tick(); force_halt_stage = 0;
        check_eq("stage6_state", state, 6);
        check_eq("stage6_cnt", cycle_cnt, 4);

        // Stop while running.
        cmd_run = 1; tick(); cmd_run = 0;
        tick(); tick();
        check_eq("stop_pre_state", state, 4);
        tick();
        cmd_stop = 1; tick(); cmd_stop = 0;
        check_eq("stop_state", state, 3);
        check_eq("stop_clk_en", cpu_clk_en, 0);
        check_eq("stop_cnt", cycle_cnt, 2);

        // Same-cycle load and run from PAUSED: load wins.
        cmd_load = 1; cmd_run = 1; tick(); cmd_load = 0; cmd_run = 0;
        check_eq("prio_state", state, 1);

        // Restart pointer mid-load.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = prog[i]; tick();
        end
        in_valid = 0;
        cmd_load = 1; tick(); cmd_load = 0;
        in_valid = 1; in_data = 8'h77; tick();
        check_eq("restart_we", mem_we, 1);
        check_eq("restart_addr", mem_addr, 0);
        check_eq("restart_data", mem_wdata, 8'h77);

        // Abort after byte 7.
        n_done = 0;
        for (int i = 1; i < 8; i++) begin
            in_valid = 1; in_data = 8'h30 + 8'(i); tick();
            if (load_done) n_done++;
        end
        in_valid = 0;
        check_eq("abort_last_addr", mem_addr, 7);
        cmd_stop = 1; tick(); cmd_stop = 0;
        if (load_done) n_done++;
        check_eq("abort_state", state, 0);
        check_eq("abort_in_ready", in_ready, 0);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_cpu_reset", cpu_reset, 1);

        // Asynchronous reset in the middle of a run.
        cmd_run = 1; tick(); cmd_run = 0;
        tick(); tick();
        check_eq("mid_run_state", state, 4);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_state", state, 0);
        check_eq("async_cpu_reset", cpu_reset, 1);
        check_eq("async_clk_en", cpu_clk_en, 0);
        check_eq("async_cnt", cycle_cnt, 0);
        check_eq("async_in_ready", in_ready, 0);
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
